// File: rtl/pianissimo_final_project_modelsim_pkg.sv
// Shared definitions for the Pianissimo drum recorder: key indices, substate codes,
// note-table entry layout, PS/2 scan codes and the seven-segment encoder.
package pianissimo_final_project_modelsim_pkg;

    localparam int KEY_N        = 5;
    localparam int keyF         = 0;
    localparam int keyG         = 1;
    localparam int keySpacebar  = 2;
    localparam int keyEnter     = 3;
    localparam int keyBackslash = 4;

    typedef enum logic [1:0] {
        subIDLE               = 2'd0,
        subSTARTNOTERECORDING = 2'd1,
        subRECORDING          = 2'd2,
        subSTOPRECORDING      = 2'd3
    } sub_state_e;

    localparam logic [1:0] PAD_NONE = 2'd0;
    localparam logic [1:0] PAD_F    = 2'd1;
    localparam logic [1:0] PAD_G    = 2'd2;

    typedef struct packed {
        logic [1:0] pad;
        logic [7:0] start;
        logic [7:0] dur;
    } note_t;

    localparam logic [7:0] PS2_F         = 8'h2B;
    localparam logic [7:0] PS2_G         = 8'h34;
    localparam logic [7:0] PS2_SPACE     = 8'h29;
    localparam logic [7:0] PS2_ENTER     = 8'h5A;
    localparam logic [7:0] PS2_BACKSLASH = 8'h5D;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;

    localparam logic [7:0]  SCREEN_W  = 8'd160;
    localparam logic [6:0]  ROW_F     = 7'd40;
    localparam logic [6:0]  ROW_G     = 7'd80;
    localparam logic [23:0] PIXEL_ON  = 24'hFFFFFF;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    function automatic logic [KEY_N-1:0] key_mask(input logic [7:0] code);
        logic [KEY_N-1:0] m;
        m = '0;
        case (code)
            PS2_F:         m[keyF]         = 1'b1;
            PS2_G:         m[keyG]         = 1'b1;
            PS2_SPACE:     m[keySpacebar]  = 1'b1;
            PS2_ENTER:     m[keyEnter]     = 1'b1;
            PS2_BACKSLASH: m[keyBackslash] = 1'b1;
            default:       m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pianissimo_final_project_modelsim_drums.sv
// Drum-recording state machine: arms on spacebar, logs F/G pad presses with start
// tick and duration into a small table, and streams held-pad pixels to the plotter.
module drums_state_controller
    import pianissimo_final_project_modelsim_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int NOTE_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_N-1:0] keys_i,
    output logic             plot_o,
    output logic [7:0]       vga_x_o,
    output logic [6:0]       vga_y_o,
    output logic [23:0]      vga_color_o,
    output logic [1:0]       state_o,
    output logic [7:0]       disp_count_o,
    output logic [1:0]       last_pad_o,
    output logic             full_o
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(NOTE_DEPTH + 1);
    localparam int IDX_W = $clog2(NOTE_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(NOTE_DEPTH);

    sub_state_e             subState;
    sub_state_e             nextSubState;
    logic [1:0]             pads_q;
    logic [DIV_W-1:0]       div_q;
    logic [7:0]             tick_q;
    logic [CNT_W-1:0]       note_count_q;
    logic                   f_act_q;
    logic                   g_act_q;
    logic [IDX_W-1:0]       f_idx_q;
    logic [IDX_W-1:0]       g_idx_q;
    logic                   full_q;
    logic [1:0]             last_pad_q;
    logic [7:0]             disp_count_q;
    logic [NOTE_DEPTH-1:0]  vld_q;
    note_t                  note_q [NOTE_DEPTH];
    logic                   plot_q;
    logic [7:0]             x_q;
    logic [6:0]             y_q;
    logic [23:0]            color_q;
    logic                   g_pend_q;
    logic [7:0]             g_x_q;

    logic                   recording;
    logic                   stopping;
    logic                   tick_en;
    logic                   f_rise;
    logic                   g_rise;
    logic                   f_wr;
    logic                   g_wr;
    logic                   f_close;
    logic                   g_close;
    logic                   drop;
    logic [CNT_W-1:0]       cnt_after_f;
    logic [CNT_W-1:0]       cnt_next;
    logic [IDX_W-1:0]       f_slot;
    logic [IDX_W-1:0]       g_slot;
    logic [7:0]             tick_x;

    always_comb begin
        nextSubState = subState;
        case (subState)
            subIDLE:
                if (keys_i[keySpacebar] && !keys_i[keyBackslash])
                    nextSubState = subSTARTNOTERECORDING;
            subSTARTNOTERECORDING: nextSubState = subRECORDING;
            subRECORDING:
                if (keys_i[keyEnter]) nextSubState = subSTOPRECORDING;
            default: nextSubState = subIDLE;
        endcase
    end

    assign recording   = (subState == subRECORDING);
    assign stopping    = (subState == subSTOPRECORDING);
    assign tick_en     = recording && (div_q == DIV_W'(TICK_DIV - 1));
    assign f_rise      = recording && keys_i[keyF] && !pads_q[0];
    assign g_rise      = recording && keys_i[keyG] && !pads_q[1];
    assign f_wr        = f_rise && (note_count_q < DEPTH_C);
    assign cnt_after_f = note_count_q + CNT_W'(f_wr);
    assign g_wr        = g_rise && (cnt_after_f < DEPTH_C);
    assign cnt_next    = cnt_after_f + CNT_W'(g_wr);
    assign drop        = (f_rise && !f_wr) || (g_rise && !g_wr);
    assign f_slot      = note_count_q[IDX_W-1:0];
    assign g_slot      = cnt_after_f[IDX_W-1:0];
    assign f_close     = f_act_q && (stopping || (recording && !keys_i[keyF] && pads_q[0]));
    assign g_close     = g_act_q && (stopping || (recording && !keys_i[keyG] && pads_q[1]));
    assign tick_x      = (tick_q >= SCREEN_W) ? (tick_q - SCREEN_W) : tick_q;

    // Note payloads are qualified by vld_q, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (f_wr) note_q[f_slot] <= '{pad: PAD_F, start: tick_q, dur: 8'd0};
        if (g_wr) note_q[g_slot] <= '{pad: PAD_G, start: tick_q, dur: 8'd0};
        if (f_close) note_q[f_idx_q].dur <= tick_q - note_q[f_idx_q].start;
        if (g_close) note_q[g_idx_q].dur <= tick_q - note_q[g_idx_q].start;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            subState     <= subIDLE;
            pads_q       <= '0;
            div_q        <= '0;
            tick_q       <= '0;
            note_count_q <= '0;
            f_act_q      <= 1'b0;
            g_act_q      <= 1'b0;
            f_idx_q      <= '0;
            g_idx_q      <= '0;
            full_q       <= 1'b0;
            last_pad_q   <= PAD_NONE;
            disp_count_q <= '0;
            vld_q        <= '0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            g_pend_q     <= 1'b0;
            g_x_q        <= '0;
        end else begin
            subState <= nextSubState;
            pads_q   <= {keys_i[keyG], keys_i[keyF]};
            plot_q   <= 1'b0;
            case (subState)
                subSTARTNOTERECORDING: begin
                    div_q        <= '0;
                    tick_q       <= '0;
                    note_count_q <= '0;
                    f_act_q      <= 1'b0;
                    g_act_q      <= 1'b0;
                    full_q       <= 1'b0;
                    vld_q        <= '0;
                end
                subRECORDING: begin
                    if (tick_en) begin
                        div_q <= '0;
                        if (tick_q != 8'hFF) tick_q <= tick_q + 8'd1;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                    note_count_q <= cnt_next;
                    if (f_wr) begin
                        vld_q[f_slot] <= 1'b1;
                        f_act_q       <= 1'b1;
                        f_idx_q       <= f_slot;
                        last_pad_q    <= PAD_F;
                    end else if (f_close) begin
                        f_act_q <= 1'b0;
                    end
                    if (g_wr) begin
                        vld_q[g_slot] <= 1'b1;
                        g_act_q       <= 1'b1;
                        g_idx_q       <= g_slot;
                        last_pad_q    <= PAD_G;
                    end else if (g_close) begin
                        g_act_q <= 1'b0;
                    end
                    if (drop) full_q <= 1'b1;
                end
                subSTOPRECORDING: begin
                    f_act_q      <= 1'b0;
                    g_act_q      <= 1'b0;
                    disp_count_q <= 8'(note_count_q);
                end
                default: ;
            endcase

            // One pixel per cycle: a deferred G pixel wins, and any tick landing on it is skipped.
            if (g_pend_q) begin
                plot_q   <= 1'b1;
                x_q      <= g_x_q;
                y_q      <= ROW_G;
                color_q  <= PIXEL_ON;
                g_pend_q <= 1'b0;
            end else if (tick_en && keys_i[keyF]) begin
                plot_q   <= 1'b1;
                x_q      <= tick_x;
                y_q      <= ROW_F;
                color_q  <= PIXEL_ON;
                g_pend_q <= keys_i[keyG];
                g_x_q    <= tick_x;
            end else if (tick_en && keys_i[keyG]) begin
                plot_q  <= 1'b1;
                x_q     <= tick_x;
                y_q     <= ROW_G;
                color_q <= PIXEL_ON;
            end
        end
    end

    assign plot_o       = plot_q;
    assign vga_x_o      = x_q;
    assign vga_y_o      = y_q;
    assign vga_color_o  = color_q;
    assign state_o      = subState;
    assign disp_count_o = disp_count_q;
    assign last_pad_o   = last_pad_q;
    assign full_o       = full_q;

endmodule

// File: rtl/pianissimo_final_project_modelsim_ps2.sv
// PS/2 receiver: synchronises the lines, shifts in 11-bit frames on falling PS2 clock
// edges and emits one-cycle set/clear masks for the tracked keys.
module ps2_key_decoder
    import pianissimo_final_project_modelsim_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ps2_clk_i,
    input  logic             ps2_dat_i,
    output logic [KEY_N-1:0] key_set_o,
    output logic [KEY_N-1:0] key_clr_o
);

    logic [1:0]  clk_sync_q;
    logic [1:0]  dat_sync_q;
    logic        clk_prev_q;
    logic [9:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic        brk_q;
    logic        fall;
    logic [10:0] frame;
    logic [7:0]  code;
    logic        frame_ok;

    assign fall     = clk_prev_q & ~clk_sync_q[1];
    assign frame    = {dat_sync_q[1], shift_q};
    assign code     = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    // Sync flops reset high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            brk_q      <= 1'b0;
            key_set_o  <= '0;
            key_clr_o  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
            key_set_o  <= '0;
            key_clr_o  <= '0;
            if (fall) begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                    if (frame_ok) begin
                        if (code == PS2_BREAK) begin
                            brk_q <= 1'b1;
                        end else if (code != PS2_EXT) begin
                            if (brk_q) key_clr_o <= key_mask(code);
                            else       key_set_o <= key_mask(code);
                            brk_q <= 1'b0;
                        end
                    end
                end else if (bit_cnt_q != 4'd0 || !dat_sync_q[1]) begin
                    shift_q   <= {dat_sync_q[1], shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/pianissimo_final_project_modelsim.sv
// Simulation-build top of the Pianissimo drum recorder: PS/2 key tracking, the drum
// recording controller and the seven-segment status displays.
module pianissimo_final_project_modelsim
    import pianissimo_final_project_modelsim_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int NOTE_DEPTH = 16
) (
    input  logic        CLOCK_50,
    output logic [23:0] VGA_COLOR,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic        plot,
    inout  wire         PS2_CLK,
    inout  wire         PS2_DAT,
    input  logic [3:0]  KEY,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6
);

    logic             rst;
    logic [KEY_N-1:0] inputStateStorage;
    logic [KEY_N-1:0] key_set;
    logic [KEY_N-1:0] key_clr;
    logic [1:0]       state;
    logic [7:0]       disp_count;
    logic [1:0]       last_pad;
    logic             full;
    logic [2:0]       unused_keys;

    assign rst         = KEY[0];
    assign unused_keys = KEY[3:1];

    ps2_key_decoder u_ps2 (
        .clk_i     (CLOCK_50),
        .rst_i     (rst),
        .ps2_clk_i (PS2_CLK),
        .ps2_dat_i (PS2_DAT),
        .key_set_o (key_set),
        .key_clr_o (key_clr)
    );

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) inputStateStorage <= '0;
        else     inputStateStorage <= (inputStateStorage | key_set) & ~key_clr;
    end

    drums_state_controller #(
        .TICK_DIV   (TICK_DIV),
        .NOTE_DEPTH (NOTE_DEPTH)
    ) mainStateDrumsController (
        .clk_i        (CLOCK_50),
        .rst_i        (rst),
        .keys_i       (inputStateStorage),
        .plot_o       (plot),
        .vga_x_o      (VGA_X),
        .vga_y_o      (VGA_Y),
        .vga_color_o  (VGA_COLOR),
        .state_o      (state),
        .disp_count_o (disp_count),
        .last_pad_o   (last_pad),
        .full_o       (full)
    );

    assign HEX0 = hex7(disp_count[3:0]);
    assign HEX1 = hex7(disp_count[7:4]);
    assign HEX2 = hex7({2'b00, state});
    assign HEX3 = hex7({2'b00, last_pad});
    assign HEX4 = hex7({3'b000, full});
    assign HEX5 = SEG_BLANK;
    assign HEX6 = SEG_BLANK;

endmodule

// File: tb/tb_pianissimo_final_project_modelsim.sv
// Directed bench for the drum recorder: key bits are forced, results compared
// against hand-computed note entries, counters, pixels and display codes.
module tb_pianissimo_final_project_modelsim;
    import pianissimo_final_project_modelsim_pkg::*;

    localparam logic [4:0] K_F     = 5'd1 << keyF;
    localparam logic [4:0] K_G     = 5'd1 << keyG;
    localparam logic [4:0] K_SPACE = 5'd1 << keySpacebar;
    localparam logic [4:0] K_ENTER = 5'd1 << keyEnter;
    localparam logic [4:0] K_BSL   = 5'd1 << keyBackslash;
    localparam logic [6:0] SEG0    = 7'b1000000;
    localparam logic [6:0] SEG1    = 7'b1111001;
    localparam logic [6:0] SEG2    = 7'b0100100;

    logic        clk = 1'b0;
    logic [3:0]  key;
    logic [4:0]  keys;
    wire  [23:0] vga_color;
    wire  [7:0]  vga_x;
    wire  [6:0]  vga_y;
    wire         plot;
    wire         ps2_clk;
    wire         ps2_dat;
    wire  [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6;

    int          checks = 0;
    int          errors = 0;
    int          plot_cnt = 0;
    int          f_pix = 0;
    int          g_pix = 0;
    int          bad_pix = 0;
    logic [7:0]  f_first_x = 8'd0;

    assign ps2_clk = 1'b1;
    assign ps2_dat = 1'b1;

    always #5 clk = ~clk;

    pianissimo_final_project_modelsim #(.TICK_DIV(1), .NOTE_DEPTH(16)) dut (
        .CLOCK_50  (clk),
        .VGA_COLOR (vga_color),
        .VGA_X     (vga_x),
        .VGA_Y     (vga_y),
        .plot      (plot),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .KEY       (key),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .HEX2      (hex2),
        .HEX3      (hex3),
        .HEX4      (hex4),
        .HEX5      (hex5),
        .HEX6      (hex6)
    );

    always @(negedge clk) begin
        if (plot) begin
            plot_cnt++;
            if (vga_y == 7'd40 && vga_color == 24'hFFFFFF) begin
                if (f_pix == 0) f_first_x = vga_x;
                f_pix++;
            end else if (vga_y == 7'd80 && vga_color == 24'hFFFFFF) begin
                g_pix++;
            end else begin
                bad_pix++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task set_keys(input logic [4:0] v);
        keys = v;
        force dut.inputStateStorage = keys;
    endtask

    // Returns in the first recording cycle, tick = 0.
    task start_rec();
        set_keys(K_SPACE);
        cyc(2);
        set_keys(5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        keys = 5'd0;
        key  = 4'b0001;
        cyc(3);
        chk("rst_state", dut.mainStateDrumsController.subState, 0);
        chk("rst_keys", dut.inputStateStorage, 0);
        chk("rst_plot", plot, 0);
        chk("rst_xy", {vga_x, vga_y}, 0);
        chk("rst_color", vga_color, 0);
        chk("rst_hex0", hex0, SEG0);
        chk("rst_hex4", hex4, SEG0);
        chk("rst_hex56", {hex5, hex6}, {7'h7F, 7'h7F});

        key = 4'b0000;
        cyc(5);
        chk("idle_state", dut.mainStateDrumsController.subState, 0);
        chk("idle_noplot", plot_cnt, 0);
        chk("idle_hex0", hex0, SEG0);

        // Record F then G: tick = cycle - 2 from the spacebar cycle.
        set_keys(K_SPACE);
        cyc(1);
        chk("start_state", dut.mainStateDrumsController.subState, 1);
        cyc(9);
        chk("rec_state", dut.mainStateDrumsController.subState, 2);
        set_keys(K_F);
        cyc(5);
        set_keys(5'd0);
        cyc(20);
        set_keys(K_G);
        cyc(5);
        set_keys(K_ENTER);
        cyc(1);
        chk("stop_state", dut.mainStateDrumsController.subState, 3);
        cyc(1);
        set_keys(5'd0);
        chk("rec_back_idle", dut.mainStateDrumsController.subState, 0);
        chk("rec_count", dut.mainStateDrumsController.note_count_q, 2);
        chk("rec_entry0", dut.mainStateDrumsController.note_q[0], {PAD_F, 8'd8, 8'd5});
        chk("rec_entry1", dut.mainStateDrumsController.note_q[1], {PAD_G, 8'd33, 8'd5});
        chk("rec_hex0", hex0, SEG2);
        chk("rec_hex3_lastpad", hex3, SEG2);
        chk("rec_f_pixels", f_pix, 5);
        chk("rec_g_pixels", g_pix, 5);
        chk("rec_f_first_x", f_first_x, 8);
        chk("rec_bad_pixels", bad_pix, 0);

        set_keys(K_SPACE | K_BSL);
        cyc(3);
        chk("piano_state", dut.mainStateDrumsController.subState, 0);
        chk("piano_count", dut.mainStateDrumsController.note_count_q, 2);
        set_keys(5'd0);
        cyc(1);

        // Re-record, then Enter while F is still held.
        start_rec();
        chk("rerec_state", dut.mainStateDrumsController.subState, 2);
        chk("rerec_count", dut.mainStateDrumsController.note_count_q, 0);
        chk("rerec_vld0", dut.mainStateDrumsController.vld_q[0], 0);
        chk("rerec_hex2", hex2, SEG2);
        cyc(2);
        set_keys(K_F);
        cyc(4);
        set_keys(K_F | K_ENTER);
        cyc(2);
        set_keys(5'd0);
        chk("held_state", dut.mainStateDrumsController.subState, 0);
        chk("held_entry0", dut.mainStateDrumsController.note_q[0], {PAD_F, 8'd2, 8'd5});
        chk("held_count", dut.mainStateDrumsController.note_count_q, 1);
        chk("held_hex0", hex0, SEG1);

        // 17 presses into a 16-entry table.
        start_rec();
        for (int i = 0; i < 17; i++) begin
            set_keys(K_F);
            cyc(2);
            set_keys(5'd0);
            cyc(2);
            if (i == 15) chk("full_at16", dut.mainStateDrumsController.full_q, 0);
        end
        chk("ovf_count", dut.mainStateDrumsController.note_count_q, 16);
        chk("ovf_full", dut.mainStateDrumsController.full_q, 1);
        chk("ovf_hex4", hex4, SEG1);
        chk("ovf_vld", dut.mainStateDrumsController.vld_q, 16'hFFFF);
        chk("ovf_entry15", dut.mainStateDrumsController.note_q[15], {PAD_F, 8'd60, 8'd2});
        set_keys(K_ENTER);
        cyc(2);
        set_keys(5'd0);
        chk("ovf_hex1", hex1, SEG1);
        chk("ovf_hex0", hex0, SEG0);

        // Reset in the middle of a recording.
        start_rec();
        set_keys(K_G);
        cyc(3);
        chk("mid_state", dut.mainStateDrumsController.subState, 2);
        chk("mid_count", dut.mainStateDrumsController.note_count_q, 1);
        #2 key = 4'b0001;
        #1;
        chk("abort_state", dut.mainStateDrumsController.subState, 0);
        chk("abort_count", dut.mainStateDrumsController.note_count_q, 0);
        chk("abort_vld", dut.mainStateDrumsController.vld_q, 0);
        chk("abort_plot", plot, 0);
        release dut.inputStateStorage;
        keys = 5'd0;
        cyc(1);
        chk("abort_keys", dut.inputStateStorage, 0);
        key = 4'b0000;
        cyc(2);
        chk("after_abort_state", dut.mainStateDrumsController.subState, 0);
        chk("after_abort_hex2", hex2, SEG0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
